// File: rtl/data_memory_stack_param_pkg.sv
// Shared defaults and mode encoding for the data memory / hardware stack.
package data_mem_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_MEM_DEPTH   = 256;
  localparam int unsigned DEF_STACK_DEPTH = 64;

  // dataMemEnable encoding
  localparam logic MODE_RAM   = 1'b1;
  localparam logic MODE_STACK = 1'b0;

endpackage

// File: rtl/data_memory_stack_param_if.sv
// Request/response bundle between the datapath (master) and the data memory (slave).
interface data_memory_stack_param_if
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
);
  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

  logic              mem_write;
  logic              mem_read;
  logic              dataMemEnable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              clear_flags;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [SP_W-1:0]   stack_sp;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_overflow;
  logic              stack_underflow;
  logic              op_error;

  modport master (
    output mem_write, mem_read, dataMemEnable, address, data_in, clear_flags,
    input  data_out, data_valid, stack_sp, stack_full, stack_empty,
           stack_overflow, stack_underflow, op_error
  );

  modport slave (
    input  mem_write, mem_read, dataMemEnable, address, data_in, clear_flags,
    output data_out, data_valid, stack_sp, stack_full, stack_empty,
           stack_overflow, stack_underflow, op_error
  );

endinterface

// File: rtl/data_memory_stack_param_stack_ctrl.sv
// Stack pointer, full/empty status, sticky overflow/underflow flags and push/pop enables.
module stack_ctrl #(
  parameter int unsigned STACK_DEPTH = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push_req,
  input  logic                               pop_req,
  input  logic                               clear_flags,
  output logic                               push_en,
  output logic                               pop_en,
  output logic [$clog2(STACK_DEPTH)-1:0]     wr_idx,
  output logic [$clog2(STACK_DEPTH)-1:0]     rd_idx,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               full,
  output logic                               empty,
  output logic                               overflow,
  output logic                               underflow
);
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  logic [SP_W-1:0] sp_q;
  logic            overflow_q;
  logic            underflow_q;

  // Status and enables; reset suppresses any array write or pop in the same cycle.
  always_comb begin
    full    = (sp_q == SP_W'(STACK_DEPTH));
    empty   = (sp_q == '0);
    push_en = push_req && !full && !reset;
    pop_en  = pop_req && !empty && !reset;
    wr_idx  = sp_q[IDX_W-1:0];
    rd_idx  = IDX_W'(sp_q - SP_W'(1));
  end

  // Pointer update and sticky flags; a same-cycle error event beats clear_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_en) begin
        sp_q <= sp_q + SP_W'(1);
      end else if (pop_en) begin
        sp_q <= sp_q - SP_W'(1);
      end
      if (push_req && full) begin
        overflow_q <= 1'b1;
      end else if (clear_flags) begin
        overflow_q <= 1'b0;
      end
      if (pop_req && empty) begin
        underflow_q <= 1'b1;
      end else if (clear_flags) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign sp        = sp_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/data_memory_stack_param.sv
// Word-addressed data RAM plus a LIFO stack sharing one registered read port.
module data_memory_stack_param
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  data_memory_stack_param_if.slave  bus
);
  localparam int unsigned MAW   = $clog2(MEM_DEPTH);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  logic [DATA_W-1:0] mem   [MEM_DEPTH];
  logic [DATA_W-1:0] stack [STACK_DEPTH];

  logic              ram_sel;
  logic              single_op;
  logic              in_range;
  logic [MAW-1:0]    mem_idx;
  logic              ram_wr;
  logic              ram_rd;
  logic              op_err_d;
  logic              push_req;
  logic              pop_req;
  logic              push_en;
  logic              pop_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              op_error_q;

  // Operation decode; read+write together is always illegal and does nothing.
  always_comb begin
    ram_sel   = (bus.dataMemEnable == MODE_RAM);
    single_op = bus.mem_write ^ bus.mem_read;
    // Compare the full address so aliases above MEM_DEPTH are rejected.
    in_range  = (bus.address < ADDR_W'(MEM_DEPTH));
    mem_idx   = bus.address[MAW-1:0];
    ram_wr    = ram_sel && single_op && bus.mem_write && in_range && !reset;
    ram_rd    = ram_sel && single_op && bus.mem_read && in_range && !reset;
    op_err_d  = (bus.mem_write && bus.mem_read) || (ram_sel && single_op && !in_range);
    push_req  = !ram_sel && bus.mem_write && !bus.mem_read;
    pop_req   = !ram_sel && bus.mem_read && !bus.mem_write;
  end

  stack_ctrl #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack_ctrl (
    .clk         (clk),
    .reset       (reset),
    .push_req    (push_req),
    .pop_req     (pop_req),
    .clear_flags (bus.clear_flags),
    .push_en     (push_en),
    .pop_en      (pop_en),
    .wr_idx      (wr_idx),
    .rd_idx      (rd_idx),
    .sp          (bus.stack_sp),
    .full        (bus.stack_full),
    .empty       (bus.stack_empty),
    .overflow    (bus.stack_overflow),
    .underflow   (bus.stack_underflow)
  );

  // RAM storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[mem_idx] <= bus.data_in;
    end
  end

  // Stack storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack[wr_idx] <= bus.data_in;
    end
  end

  // Shared output register: data_out holds unless a read or pop succeeds.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      op_error_q   <= 1'b0;
    end else begin
      data_valid_q <= ram_rd || pop_en;
      op_error_q   <= op_err_d;
      if (ram_rd) begin
        data_out_q <= mem[mem_idx];
      end else if (pop_en) begin
        data_out_q <= stack[rd_idx];
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.op_error   = op_error_q;

endmodule

// File: tb/tb_data_memory_stack_param.sv
// Directed bench for data_memory_stack_param: RAM, stack, status flags and reset abort.
module tb_data_memory_stack_param;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  data_memory_stack_param_if bus ();

  data_memory_stack_param dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are checked at the next falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic mode, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] din, input logic clr);
    bus.dataMemEnable = mode;
    bus.mem_write     = wr;
    bus.mem_read      = rd;
    bus.address       = addr;
    bus.data_in       = din;
    bus.clear_flags   = clr;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Reset state
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_valid", bus.data_valid, 0);
    chk("rst_op_error", bus.op_error, 0);
    chk("rst_sp", bus.stack_sp, 0);
    chk("rst_empty", bus.stack_empty, 1);
    chk("rst_full", bus.stack_full, 0);
    chk("rst_ovf", bus.stack_overflow, 0);
    chk("rst_unf", bus.stack_underflow, 0);

    // 1: RAM write then read of the same word
    drive(1'b1, 1'b1, 1'b0, 32'd5, 32'hDEADBEEF, 1'b0);
    cycle();
    chk("t1_wr_valid", bus.data_valid, 0);
    chk("t1_wr_op_error", bus.op_error, 0);
    drive(1'b1, 1'b0, 1'b1, 32'd5, 32'h0, 1'b0);
    cycle();
    chk("t1_rd_data", bus.data_out, 32'hDEADBEEF);
    chk("t1_rd_valid", bus.data_valid, 1);
    idle();
    cycle();
    chk("t1_hold_data", bus.data_out, 32'hDEADBEEF);
    chk("t1_valid_pulse", bus.data_valid, 0);

    // Top word of the RAM is in range
    drive(1'b1, 1'b1, 1'b0, 32'd255, 32'h12345678, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 32'd255, 32'h0, 1'b0);
    cycle();
    chk("t1_top_data", bus.data_out, 32'h12345678);
    chk("t1_top_err", bus.op_error, 0);

    // 2: out-of-range write must not alias onto 300 mod 256 = 44
    drive(1'b1, 1'b1, 1'b0, 32'd44, 32'h00004444, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 32'd300, 32'h1, 1'b0);
    cycle();
    chk("t2_wr_op_error", bus.op_error, 1);
    chk("t2_wr_valid", bus.data_valid, 0);
    chk("t2_wr_data", bus.data_out, 32'h12345678);
    drive(1'b1, 1'b0, 1'b1, 32'd256, 32'h0, 1'b0);
    cycle();
    chk("t2_rd_op_error", bus.op_error, 1);
    chk("t2_rd_valid", bus.data_valid, 0);
    chk("t2_rd_data", bus.data_out, 32'h12345678);
    idle();
    cycle();
    chk("t2_err_pulse", bus.op_error, 0);
    drive(1'b1, 1'b0, 1'b1, 32'd44, 32'h0, 1'b0);
    cycle();
    chk("t2_alias_intact", bus.data_out, 32'h00004444);

    // 3: push A, B, C then pop in reverse
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hA, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hB, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hC, 1'b0);
    cycle();
    chk("t3_sp3", bus.stack_sp, 3);
    chk("t3_push_valid", bus.data_valid, 0);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    cycle();
    chk("t3_pop1", bus.data_out, 32'hC);
    chk("t3_pop1_valid", bus.data_valid, 1);
    chk("t3_sp2", bus.stack_sp, 2);
    cycle();
    chk("t3_pop2", bus.data_out, 32'hB);
    chk("t3_sp1", bus.stack_sp, 1);
    cycle();
    chk("t3_pop3", bus.data_out, 32'hA);
    chk("t3_sp0", bus.stack_sp, 0);
    chk("t3_empty", bus.stack_empty, 1);

    // 4: fill, overflow, pop, clear, slot reuse
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h100 + 32'(i), 1'b0);
      cycle();
    end
    chk("t4_full", bus.stack_full, 1);
    chk("t4_sp64", bus.stack_sp, 64);
    chk("t4_ovf_clear", bus.stack_overflow, 0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF, 1'b0);
    cycle();
    chk("t4_ovf", bus.stack_overflow, 1);
    chk("t4_ovf_sp", bus.stack_sp, 64);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    cycle();
    chk("t4_pop_last", bus.data_out, 32'h13F);
    chk("t4_pop_sp", bus.stack_sp, 63);
    chk("t4_not_full", bus.stack_full, 0);
    chk("t4_ovf_sticky", bus.stack_overflow, 1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle();
    chk("t4_ovf_cleared", bus.stack_overflow, 0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h77, 1'b0);
    cycle();
    chk("t4_reuse_full", bus.stack_full, 1);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    cycle();
    chk("t4_reuse_pop", bus.data_out, 32'h77);
    for (int i = 0; i < 63; i++) begin
      cycle();
    end
    chk("t4_drain_data", bus.data_out, 32'h100);
    chk("t4_drain_empty", bus.stack_empty, 1);

    // 5: underflow, event-beats-clear, illegal read+write
    cycle();
    chk("t5_unf", bus.stack_underflow, 1);
    chk("t5_unf_valid", bus.data_valid, 0);
    chk("t5_unf_data", bus.data_out, 32'h100);
    chk("t5_unf_sp", bus.stack_sp, 0);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    cycle();
    chk("t5_unf_wins_clear", bus.stack_underflow, 1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle();
    chk("t5_unf_cleared", bus.stack_underflow, 0);
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h55, 1'b0);
    cycle();
    chk("t5_stk_both_err", bus.op_error, 1);
    chk("t5_stk_both_sp", bus.stack_sp, 0);
    chk("t5_stk_both_valid", bus.data_valid, 0);
    chk("t5_stk_both_unf", bus.stack_underflow, 0);
    drive(1'b1, 1'b1, 1'b1, 32'd5, 32'h0, 1'b0);
    cycle();
    chk("t5_ram_both_err", bus.op_error, 1);
    chk("t5_ram_both_data", bus.data_out, 32'h100);
    drive(1'b1, 1'b0, 1'b1, 32'd5, 32'h0, 1'b0);
    cycle();
    chk("t5_ram_intact", bus.data_out, 32'hDEADBEEF);
    chk("t5_err_pulse", bus.op_error, 0);

    // 6: reset aborts a pop
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h61, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h62, 1'b0);
    cycle();
    chk("t6_sp2", bus.stack_sp, 2);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_rst_sp", bus.stack_sp, 0);
    chk("t6_rst_data", bus.data_out, 0);
    chk("t6_rst_valid", bus.data_valid, 0);
    chk("t6_rst_unf", bus.stack_underflow, 0);
    chk("t6_rst_ovf", bus.stack_overflow, 0);
    cycle();
    chk("t6_pop_unf", bus.stack_underflow, 1);
    chk("t6_pop_valid", bus.data_valid, 0);
    chk("t6_pop_data", bus.data_out, 0);

    idle();
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
